// File: rtl/ascon_perm_engine_pkg.sv
// Shared definitions for the Ascon permutation engine: state geometry, FSM
// encoding, rotation amounts and the round-constant helper.
package ascon_perm_engine_pkg;

  localparam int WORD_W    = 64;
  localparam int NUM_WORDS = 5;
  localparam int STATE_W   = WORD_W * NUM_WORDS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int ROT_X0_A = 19;
  localparam int ROT_X0_B = 28;
  localparam int ROT_X1_A = 61;
  localparam int ROT_X1_B = 39;
  localparam int ROT_X2_A = 1;
  localparam int ROT_X2_B = 6;
  localparam int ROT_X3_A = 10;
  localparam int ROT_X3_B = 17;
  localparam int ROT_X4_A = 7;
  localparam int ROT_X4_B = 41;

  // High nibble counts down while the low nibble counts up with the round index.
  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'd15 - r, r};
  endfunction

  function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] v, input int n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear layer.
module ascon_round
  import ascon_perm_engine_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [3:0]         r,
  output logic [STATE_W-1:0] state_next
);

  logic [WORD_W-1:0] a0, a1, a2, a3, a4;
  logic [WORD_W-1:0] b0, b2, b4;
  logic [WORD_W-1:0] c0, c1, c2, c3, c4;
  logic [WORD_W-1:0] d0, d1, d2, d3, d4;

  assign a0 = state[319:256];
  assign a1 = state[255:192];
  assign a2 = state[191:128] ^ {56'd0, round_const(r)};
  assign a3 = state[127:64];
  assign a4 = state[63:0];

  // S-box applied to all 64 columns at once, one word per bit plane.
  assign b0 = a0 ^ a4;
  assign b4 = a4 ^ a3;
  assign b2 = a2 ^ a1;

  assign c0 = b0 ^ (~a1 & b2);
  assign c1 = a1 ^ (~b2 & a3);
  assign c2 = b2 ^ (~a3 & b4);
  assign c3 = a3 ^ (~b4 & b0);
  assign c4 = b4 ^ (~b0 & a1);

  assign d0 = c0 ^ c4;
  assign d1 = c1 ^ c0;
  assign d2 = ~c2;
  assign d3 = c3 ^ c2;
  assign d4 = c4;

  assign state_next = {
    d0 ^ ror64(d0, ROT_X0_A) ^ ror64(d0, ROT_X0_B),
    d1 ^ ror64(d1, ROT_X1_A) ^ ror64(d1, ROT_X1_B),
    d2 ^ ror64(d2, ROT_X2_A) ^ ror64(d2, ROT_X2_B),
    d3 ^ ror64(d3, ROT_X3_A) ^ ror64(d3, ROT_X3_B),
    d4 ^ ror64(d4, ROT_X4_A) ^ ror64(d4, ROT_X4_B)
  };

endmodule

// File: rtl/ascon_perm_engine.sv
// Iterative Ascon permutation: one round per clock over a 320-bit working register.
module ascon_perm_engine
  import ascon_perm_engine_pkg::*;
#(
  parameter int MAX_ROUNDS = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_perm,
  input  logic [3:0]         perm_rounds,
  input  logic [STATE_W-1:0] state_in,
  output logic [STATE_W-1:0] state_out,
  output logic               perm_done,
  output logic               busy
);

  logic [1:0]         fsm;
  logic [STATE_W-1:0] work;
  logic [STATE_W-1:0] work_next;
  logic [3:0]         rnd;
  logic [3:0]         count;
  logic [3:0]         a_eff;

  assign a_eff = (perm_rounds > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : perm_rounds;

  ascon_round u_round (
    .state      (work),
    .r          (rnd),
    .state_next (work_next)
  );

  // Rounds run at indices MAX_ROUNDS-a .. MAX_ROUNDS-1; a zero-round request skips RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= ST_IDLE;
      work  <= '0;
      rnd   <= '0;
      count <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (start_perm) begin
            work  <= state_in;
            rnd   <= 4'(MAX_ROUNDS) - a_eff;
            count <= a_eff;
            fsm   <= (a_eff == 4'd0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          work  <= work_next;
          rnd   <= rnd + 4'd1;
          count <= count - 4'd1;
          if (count == 4'd1) fsm <= ST_DONE;
        end
        ST_DONE: fsm <= ST_IDLE;
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  assign state_out = work;
  assign perm_done = (fsm == ST_DONE);
  assign busy      = (fsm != ST_IDLE);

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Scoreboard bench for ascon_perm_engine against a table-driven Ascon model.
module tb_ascon_perm_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_perm = 1'b0;
  logic [3:0]   perm_rounds = 4'd0;
  logic [319:0] state_in = '0;
  logic [319:0] state_out;
  logic         perm_done;
  logic         busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [319:0] st;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam logic [319:0] IV_IN = {64'h00400c0000000100, 256'd0};
  localparam logic [319:0] IV_OUT = {
    64'hee9398aadb67f03d, 64'h8bb21831c60f1002, 64'hb48a92db98d5da62,
    64'h43189921b8f8e3e8, 64'h348fa5c9d525e140
  };

  ascon_perm_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_perm  (start_perm),
    .perm_rounds (perm_rounds),
    .state_in    (state_in),
    .state_out   (state_out),
    .perm_done   (perm_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Model: per-column S-box lookup on five separate words.
  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int a_req);
    logic [63:0] x [5];
    logic [4:0]  col;
    logic [4:0]  o;
    int          a;
    int          rot [10];
    a = (a_req > 12) ? 12 : a_req;
    rot = '{19, 28, 61, 39, 1, 6, 10, 17, 7, 41};
    for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
    for (int r = 12 - a; r < 12; r++) begin
      x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
      for (int c = 0; c < 64; c++) begin
        col = {x[0][c], x[1][c], x[2][c], x[3][c], x[4][c]};
        o = SBOX[col];
        for (int w = 0; w < 5; w++) x[w][c] = o[4 - w];
      end
      for (int w = 0; w < 5; w++)
        x[w] = x[w] ^ rotr(x[w], rot[2*w]) ^ rotr(x[w], rot[2*w + 1]);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every perm_done pulse must match the oldest outstanding job.
  always @(negedge clk) begin
    if (rst_n && perm_done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("state_out", state_out, e.st);
        checkOutput("done_cycle", 320'(cyc), 320'(e.cyc));
      end
    end
  end

  // Issues one job from IDLE, scrambles inputs while busy and checks the busy window.
  task automatic applyStimulus(input logic [3:0] a, input logic [319:0] s, input logic [319:0] exp_st);
    int c0;
    int aeff;
    aeff = (a > 4'd12) ? 12 : int'(a);
    c0 = cyc;
    start_perm = 1'b1;
    perm_rounds = a;
    state_in = s;
    sb.push_back('{exp_st, c0 + aeff + 1});
    @(posedge clk); #1;
    start_perm = 1'b0;
    for (int k = 1; k <= aeff + 2; k++) begin
      checkOutput("busy", 320'(busy), 320'(k <= aeff + 1));
      state_in = rand320();
      perm_rounds = 4'($urandom_range(0, 15));
      if (k < aeff + 2) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [319:0] s;
    logic [3:0]   a;
    int           c0;

    #2;
    checkOutput("reset_state_out", state_out, '0);
    checkOutput("reset_busy", 320'(busy), '0);
    checkOutput("reset_done", 320'(perm_done), '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(4'd12, IV_IN, IV_OUT);
    applyStimulus(4'd15, IV_IN, IV_OUT);
    s = rand320();
    applyStimulus(4'd6, s, ref_perm(s, 6));
    s = rand320();
    applyStimulus(4'd1, s, ref_perm(s, 1));
    s = rand320();
    applyStimulus(4'd0, s, s);
    for (int i = 0; i < 8; i++) begin
      s = rand320();
      a = 4'($urandom_range(0, 15));
      applyStimulus(a, s, ref_perm(s, int'(a)));
    end

    // Back-to-back: start held high, fresh state_in every cycle.
    c0 = cyc;
    start_perm = 1'b1;
    perm_rounds = 4'd6;
    for (int k = 0; k <= 16; k++) begin
      state_in = rand320();
      if (k == 0 || k == 8 || k == 16) sb.push_back('{ref_perm(state_in, 6), c0 + k + 7});
      @(posedge clk); #1;
    end
    start_perm = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    checkOutput("b2b_pending", 320'(sb.size()), '0);

    // Reset in cycle 5 of an a=12 run: the job must vanish without a pulse.
    start_perm = 1'b1;
    perm_rounds = 4'd12;
    state_in = rand320();
    @(posedge clk); #1;
    start_perm = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abort_state_out", state_out, '0);
    checkOutput("abort_busy", 320'(busy), '0);
    checkOutput("abort_done", 320'(perm_done), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
    end
    checkOutput("post_abort_busy", 320'(busy), '0);
    applyStimulus(4'd12, IV_IN, IV_OUT);

    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("final_pending", 320'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
